jesd204b_lane_sync: RTL and testbench
=====================================

Name: jesd204b_lane_sync

Overview:
Per-lane link-establishment stage of the JESD204B receiver. It sits between the 8b/10b decoder and the elastic buffer, and runs code group synchronisation (CGS), the initial lane alignment sequence (ILAS) and data-phase monitoring. It drives the SYNC~ request back to the transmitter. It forwards the decoded lane words to the elastic buffer and generates the buffer's write-enable (ready) signal.

Parameters:
DATA_WIDTH, 32, lane word width in bits; must be a multiple of 8; octets per word OCT = DATA_WIDTH/8; octet 0 = bits [7:0] = earliest octet.
CGS_COUNT, 4, consecutive all-comma words required to complete CGS (range 1..255).
ILAS_MF, 4, number of ILAS multiframes, each terminated by /A/ (range 1..15).
ILAS_TIMEOUT, 1024, maximum words spent in ILAS_WAIT+ILAS before aborting to CGS.
ERR_THRESH, 8, consecutive errored words in DATA that force resynchronisation (range 1..255).

Ports:
clk_i  input  1  lane clock
rst_ni  input  1  asynchronous active-low reset
enable_i  input  1  link enable; low forces CGS
data_i  input  DATA_WIDTH  decoded lane word, one per cycle
charisk_i  input  OCT  per-octet K-character flag
disperr_i  input  OCT  per-octet running-disparity error
notintable_i  input  OCT  per-octet not-in-table error
data_o  output  DATA_WIDTH  registered lane word to elastic buffer in_data_i
ready_o  output  1  high = write data_o into buffer (drives elastic buffer ready_ni)
sync_no  output  1  SYNC~ to transmitter, low = request synchronisation
state_o  output  2  0=CGS, 1=ILAS_WAIT, 2=ILAS, 3=DATA
ilas_done_o  output  1  one-cycle pulse on entry to DATA
err_cnt_o  output  16  saturating count of errored words in DATA

Behaviour:
- Reset (async assert, sync release): state CGS; sync_no=0, ready_o=0, ilas_done_o=0, data_o=0, err_cnt_o=0, and all internal counters 0.
- Word classes, evaluated per sampled word:
  - err = any bit of disperr_i or notintable_i set.
  - comma = every octet is 0xBC with its charisk bit set, and not err.
  - rstart = octet 0 is 0x1C with charisk[0] set, and not err.
  - afound = octet OCT-1 is 0x7C with charisk[OCT-1] set.
- enable_i=0 takes priority over everything: at the next edge, state CGS, sync_no=0, ready_o=0, counters cleared. err_cnt_o is kept.
- CGS: sync_no=0. A comma word increments cgs_cnt; any other word clears it. When the CGS_COUNT-th consecutive comma word is sampled, the next state is ILAS_WAIT and sync_no=1 from that edge.
- ILAS_WAIT:
  - Comma words: stay in ILAS_WAIT.
  - rstart: go to ILAS; mf_cnt=0; the /A/ check also applies to this same word.
  - Any other word (including err, or /R/ outside octet 0): go to CGS, sync_no=0.
- ILAS:
  - afound increments mf_cnt.
  - err causes an immediate abort to CGS.
  - When the ILAS_MF-th /A/ word is sampled, state becomes DATA at that edge and ilas_done_o=1 for exactly one cycle. sync_no stays 1.
  - ILAS contents (configuration octets) are not checked.
- Timeout: a word counter runs in ILAS_WAIT and ILAS. On reaching ILAS_TIMEOUT words without entering DATA, go to CGS with sync_no=0.
- DATA:
  - Each err word increments err_cnt_o (saturates at 0xFFFF) and the consecutive-error counter.
  - A clean word clears the consecutive-error counter.
  - On the ERR_THRESH-th consecutive err word: go to CGS, sync_no=0, ready_o=0 at that edge.
- Latency and ready timing:
  - data_o = data_i registered every cycle, fixed 1-cycle latency, independent of state.
  - ready_o is registered alongside data_o and equals "state was DATA when this word was sampled".
  - Consequence: the last ILAS word is never written. The first word after the final /A/ appears on data_o with ready_o=1.
  - ready_o falls in the same cycle that data_o carries the word that triggered the resync.
- Only reset clears err_cnt_o; re-entering CGS does not.

Test Plan:
- Reset, enable_i=1, 3 comma words, one 0x00000000 word, then 4 comma words -> sync_no stays 0 for the first 4 words. sync_no rises the edge after the 8th word; state_o=1.
- After CGS, 2 comma words, /R/ word 0x0000001C (charisk=0001), then words so that 4 words carry 0x7C in octet 3 (charisk=1000), then data 0xA5A5A5A5 -> ilas_done_o pulses once. The first data_o with ready_o=1 is 0xA5A5A5A5, one cycle after it is sampled.
- In ILAS_WAIT, drive 0x1C000000 with charisk=1000 -> state_o returns to 0 and sync_no=0 on the next edge.
- In DATA, 7 words with disperr_i=0001, one clean word, then 8 errored words -> err_cnt_o=15. After the 8th consecutive error: ready_o=0, sync_no=0, state_o=0.
- Stay in ILAS_WAIT with comma words for 1024 words -> CGS and sync_no=0. Also drop enable_i for 1 cycle mid-ILAS -> CGS and counters cleared, err_cnt_o unchanged.
- Assert rst_ni=0 asynchronously mid-DATA -> all outputs are at reset values before the next clock edge. With 65540 error words and ERR_THRESH=255 interleaved with clean words, err_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/jesd204b_lane_sync.sv
// JESD204B per-lane link establishment: code group synchronisation, initial
// lane alignment sequence tracking and data-phase error monitoring. Drives
// SYNC~ back to the transmitter and the write strobe of the elastic buffer.
module jesd204b_lane_sync #(
  parameter int DATA_WIDTH   = 32,
  parameter int CGS_COUNT    = 4,
  parameter int ILAS_MF      = 4,
  parameter int ILAS_TIMEOUT = 1024,
  parameter int ERR_THRESH   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] charisk_i,
  input  logic [DATA_WIDTH/8-1:0] disperr_i,
  input  logic [DATA_WIDTH/8-1:0] notintable_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    ready_o,
  output logic                    sync_no,
  output logic [1:0]              state_o,
  output logic                    ilas_done_o,
  output logic [15:0]             err_cnt_o
);

  localparam int OCT = DATA_WIDTH / 8;
  localparam int TW  = $clog2(ILAS_TIMEOUT + 1);

  localparam logic [1:0] ST_CGS  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ILAS = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  // Word classification helpers
  function automatic logic word_err(input logic [OCT-1:0] de, input logic [OCT-1:0] nt);
    return (|de) | (|nt);
  endfunction

  function automatic logic all_comma(input logic [DATA_WIDTH-1:0] d, input logic [OCT-1:0] k);
    logic r;
    r = 1'b1;
    for (int i = 0; i < OCT; i++) begin
      r = r & k[i] & (d[8*i +: 8] == 8'hBC);
    end
    return r;
  endfunction

  function automatic logic is_rstart(input logic [DATA_WIDTH-1:0] d, input logic [OCT-1:0] k);
    return k[0] & (d[7:0] == 8'h1C);
  endfunction

  function automatic logic is_afound(input logic [DATA_WIDTH-1:0] d, input logic [OCT-1:0] k);
    return k[OCT-1] & (d[DATA_WIDTH-1 -: 8] == 8'h7C);
  endfunction

  logic [1:0]            state_r;
  logic [1:0]            state_calc_s;
  logic [1:0]            state_nxt_s;
  logic                  go_cgs_s;
  logic [7:0]            cgs_cnt_r, cgs_nxt_s;
  logic [3:0]            mf_cnt_r, mf_nxt_s;
  logic [TW-1:0]         tmo_cnt_r, tmo_nxt_s;
  logic [7:0]            run_r, run_nxt_s;
  logic [15:0]           err_cnt_r, err_cnt_nxt_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  ready_r, sync_r, done_r;
  logic                  ready_nxt_s, sync_nxt_s, done_nxt_s;

  logic err_s, comma_s, rstart_s, afound_s;
  logic cgs_last_s, mf_last_s, tmo_last_s, run_last_s;

  assign err_s    = word_err(disperr_i, notintable_i);
  assign comma_s  = all_comma(data_i, charisk_i) & ~err_s;
  assign rstart_s = is_rstart(data_i, charisk_i) & ~err_s;
  assign afound_s = is_afound(data_i, charisk_i);

  // The current word is the (count+1)-th, so "last" compares against N-1
  assign cgs_last_s = (cgs_cnt_r == 8'(CGS_COUNT - 1));
  assign mf_last_s  = (mf_cnt_r == 4'(ILAS_MF - 1));
  assign tmo_last_s = (tmo_cnt_r == TW'(ILAS_TIMEOUT - 1));
  assign run_last_s = (run_r == 8'(ERR_THRESH - 1));

  // Any exit back to CGS overrides the state computed by the case below
  assign state_nxt_s = go_cgs_s ? ST_CGS : state_calc_s;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_CGS;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and counter update logic; mf_cnt is always zero in ILAS_WAIT,
  // so mf_last there means a single /A/ on the /R/ word completes ILAS
  always_comb begin
    go_cgs_s      = 1'b0;
    state_calc_s  = state_r;
    cgs_nxt_s     = cgs_cnt_r;
    mf_nxt_s      = mf_cnt_r;
    tmo_nxt_s     = tmo_cnt_r;
    run_nxt_s     = run_r;
    err_cnt_nxt_s = err_cnt_r;
    if (!enable_i) begin
      go_cgs_s = 1'b1;
    end else begin
      case (state_r)
        ST_CGS: begin
          if (comma_s) begin
            if (cgs_last_s) begin
              state_calc_s = ST_WAIT;
              cgs_nxt_s    = 8'd0;
              tmo_nxt_s    = '0;
            end else begin
              cgs_nxt_s = cgs_cnt_r + 8'd1;
            end
          end else begin
            cgs_nxt_s = 8'd0;
          end
        end
        ST_WAIT: begin
          if (comma_s) begin
            if (tmo_last_s) begin
              go_cgs_s = 1'b1;
            end else begin
              tmo_nxt_s = tmo_cnt_r + TW'(1);
            end
          end else if (rstart_s) begin
            if (afound_s && mf_last_s) begin
              state_calc_s = ST_DATA;
              mf_nxt_s     = 4'd0;
              run_nxt_s    = 8'd0;
            end else if (tmo_last_s) begin
              go_cgs_s = 1'b1;
            end else begin
              state_calc_s = ST_ILAS;
              mf_nxt_s     = mf_cnt_r + {3'b000, afound_s};
              tmo_nxt_s    = tmo_cnt_r + TW'(1);
            end
          end else begin
            go_cgs_s = 1'b1;
          end
        end
        ST_ILAS: begin
          if (err_s) begin
            go_cgs_s = 1'b1;
          end else if (afound_s && mf_last_s) begin
            state_calc_s = ST_DATA;
            mf_nxt_s     = 4'd0;
            run_nxt_s    = 8'd0;
          end else if (tmo_last_s) begin
            go_cgs_s = 1'b1;
          end else begin
            mf_nxt_s  = mf_cnt_r + {3'b000, afound_s};
            tmo_nxt_s = tmo_cnt_r + TW'(1);
          end
        end
        ST_DATA: begin
          if (err_s) begin
            err_cnt_nxt_s = (err_cnt_r == 16'hFFFF) ? err_cnt_r : err_cnt_r + 16'd1;
            if (run_last_s) begin
              go_cgs_s = 1'b1;
            end else begin
              run_nxt_s = run_r + 8'd1;
            end
          end else begin
            run_nxt_s = 8'd0;
          end
        end
        default: begin
          go_cgs_s = 1'b1;
        end
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    sync_nxt_s  = (state_nxt_s != ST_CGS);
    ready_nxt_s = (state_r == ST_DATA) && (state_nxt_s == ST_DATA);
    done_nxt_s  = (state_r != ST_DATA) && (state_nxt_s == ST_DATA);
  end

  // Link counters; a return to CGS clears all but the error total
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cgs_cnt_r <= 8'd0;
      mf_cnt_r  <= 4'd0;
      tmo_cnt_r <= '0;
      run_r     <= 8'd0;
      err_cnt_r <= 16'd0;
    end else begin
      err_cnt_r <= err_cnt_nxt_s;
      if (go_cgs_s) begin
        cgs_cnt_r <= 8'd0;
        mf_cnt_r  <= 4'd0;
        tmo_cnt_r <= '0;
        run_r     <= 8'd0;
      end else begin
        cgs_cnt_r <= cgs_nxt_s;
        mf_cnt_r  <= mf_nxt_s;
        tmo_cnt_r <= tmo_nxt_s;
        run_r     <= run_nxt_s;
      end
    end
  end

  // Output registers: data is forwarded every cycle, ready marks DATA words
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_r  <= '0;
      ready_r <= 1'b0;
      sync_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      data_r  <= data_i;
      ready_r <= ready_nxt_s;
      sync_r  <= sync_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign data_o      = data_r;
  assign ready_o     = ready_r;
  assign sync_no     = sync_r;
  assign state_o     = state_r;
  assign ilas_done_o = done_r;
  assign err_cnt_o   = err_cnt_r;

endmodule

// File: tb/tb_jesd204b_lane_sync.sv
// Bench for jesd204b_lane_sync: directed and random word streams are run
// through a phase-level reference model whose predictions are queued and
// compared against the outputs by an independent monitor. A second instance
// with a high error threshold exercises error counter saturation.
module tb_jesd204b_lane_sync;

  localparam int CGS_N = 4;
  localparam int MF_N  = 4;
  localparam int TO_N  = 1024;
  localparam int ETH   = 8;
  localparam int P_CGS = 0, P_WAIT = 1, P_ILAS = 2, P_DATA = 3;
  localparam logic [31:0] COMMA = 32'hBCBCBCBC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en;
  logic [31:0] din;
  logic [3:0]  kin, dein, ntin;
  logic [31:0] dout;
  logic        rdy, syncn, done;
  logic [1:0]  st;
  logic [15:0] ecnt;

  logic        rst2_n, en2;
  logic [31:0] d2;
  logic [3:0]  k2, de2, nt2;
  logic [31:0] dout2;
  logic        rdy2, syncn2, done2o;
  logic [1:0]  st2;
  logic [15:0] ecnt2;
  logic        fin2;

  jesd204b_lane_sync u_dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .data_i(din), .charisk_i(kin),
    .disperr_i(dein), .notintable_i(ntin), .data_o(dout), .ready_o(rdy),
    .sync_no(syncn), .state_o(st), .ilas_done_o(done), .err_cnt_o(ecnt)
  );

  jesd204b_lane_sync #(.ERR_THRESH(255)) u_sat (
    .clk_i(clk), .rst_ni(rst2_n), .enable_i(en2), .data_i(d2), .charisk_i(k2),
    .disperr_i(de2), .notintable_i(nt2), .data_o(dout2), .ready_o(rdy2),
    .sync_no(syncn2), .state_o(st2), .ilas_done_o(done2o), .err_cnt_o(ecnt2)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
    logic        sync_n;
    logic [1:0]  state;
    logic        done;
    logic [15:0] errc;
  } obs_t;

  typedef struct packed {
    int   cyc;
    obs_t o;
  } sb_t;

  sb_t  sbq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  sb_t  mon_e;
  obs_t mon_g;

  // Reference model state: link phase and the counts the rules refer to
  int m_ph, m_cgs, m_af, m_words, m_run, m_err;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] octet(input logic [31:0] d, input int i);
    logic [31:0] t;
    t = d >> (8 * i);
    return t[7:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  task automatic to_cgs();
    m_ph = P_CGS; m_cgs = 0; m_af = 0; m_words = 0; m_run = 0;
  endtask

  task automatic model_reset();
    to_cgs();
    m_err = 0;
  endtask

  task automatic model_step(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                            input logic [3:0] nt, input logic e, output obs_t o);
    bit bad, com, rs, af;
    int prev;
    bad = (de != 4'd0) || (nt != 4'd0);
    com = !bad;
    for (int i = 0; i < 4; i++) if (octet(d, i) != 8'hBC || !k[i]) com = 1'b0;
    rs = !bad && octet(d, 0) == 8'h1C && k[0];
    af = octet(d, 3) == 8'h7C && k[3];
    prev = m_ph;
    if (!e) to_cgs();
    else if (m_ph == P_CGS) begin
      if (com) begin
        m_cgs++;
        if (m_cgs == CGS_N) begin m_ph = P_WAIT; m_cgs = 0; m_words = 0; end
      end else m_cgs = 0;
    end else if (m_ph == P_WAIT) begin
      m_words++;
      if (com) begin
        if (m_words == TO_N) to_cgs();
      end else if (rs) begin
        m_af = af ? 1 : 0;
        if (m_af == MF_N) begin m_ph = P_DATA; m_run = 0; end
        else if (m_words == TO_N) to_cgs();
        else m_ph = P_ILAS;
      end else to_cgs();
    end else if (m_ph == P_ILAS) begin
      m_words++;
      if (bad) to_cgs();
      else begin
        if (af) m_af++;
        if (m_af == MF_N) begin m_ph = P_DATA; m_run = 0; end
        else if (m_words == TO_N) to_cgs();
      end
    end else begin
      if (bad) begin
        if (m_err < 65535) m_err++;
        m_run++;
        if (m_run == ETH) to_cgs();
      end else m_run = 0;
    end
    o.data   = d;
    o.ready  = (prev == P_DATA) && (m_ph == P_DATA);
    o.sync_n = (m_ph != P_CGS);
    o.state  = 2'(m_ph);
    o.done   = (prev != P_DATA) && (m_ph == P_DATA);
    o.errc   = 16'(m_err);
  endtask

  // Applies one word (called at posedge+1), queues its prediction, advances one cycle
  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                       input logic [3:0] nt, input logic e);
    obs_t o;
    sb_t  s;
    en = e; din = d; kin = k; dein = de; ntin = nt;
    model_step(d, k, de, nt, e, o);
    s.cyc = cyc + 1;
    s.o   = o;
    sbq.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic w(input logic [31:0] d, input logic [3:0] k);
    drive(d, k, 4'd0, 4'd0, 1'b1);
  endtask

  task automatic commas(input int n);
    repeat (n) w(COMMA, 4'hF);
  endtask

  task automatic err_word();
    if ($urandom_range(0, 1) == 0) drive($urandom, 4'd0, 4'(1 << $urandom_range(0, 3)), 4'd0, 1'b1);
    else drive($urandom, 4'd0, 4'd0, 4'($urandom_range(1, 15)), 1'b1);
  endtask

  task automatic go_to_data();
    drive(32'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    commas(CGS_N);
    w({24'($urandom), 8'h1C}, 4'b0001);
    repeat (MF_N) w({8'h7C, 24'($urandom)}, 4'b1000);
  endtask

  task automatic episode();
    int lvl;
    repeat ($urandom_range(2, 6)) begin
      if ($urandom_range(0, 15) == 0) w($urandom, 4'($urandom));
      else commas(1);
    end
    if ($urandom_range(0, 7) == 0) w(32'h1C000000, 4'b1000);
    else w({24'($urandom), 8'h1C}, 4'b0001);
    for (int m = 0; m < MF_N; m++) begin
      repeat ($urandom_range(0, 4)) w($urandom, 4'd0);
      if ($urandom_range(0, 19) == 0) err_word();
      w({8'h7C, 24'($urandom)}, 4'b1000);
    end
    lvl = $urandom_range(0, 3);
    repeat ($urandom_range(5, 40)) begin
      if ($urandom_range(0, 63) == 0) drive($urandom, 4'd0, 4'd0, 4'd0, 1'b0);
      else if ($urandom_range(0, 3) < lvl) err_word();
      else w($urandom, 4'd0);
    end
  endtask

  task automatic async_reset_check();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 64'({dout, rdy, syncn, st, done, ecnt}), 64'd0);
    sbq.delete();
    model_reset();
    en = 1'b0; din = 32'd0; kin = 4'd0; dein = 4'd0; ntin = 4'd0;
    @(posedge clk);
    #1;
    chk("rst_hold", 64'({dout, rdy, syncn, st, done, ecnt}), 64'd0);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every queued prediction against the outputs of its cycle
  always @(posedge clk) begin
    #2;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      mon_g = {dout, rdy, syncn, st, done, ecnt};
      n_chk++;
      if (mon_e.cyc == cyc && mon_g === mon_e.o) n_pass++;
      else $display("FAIL sb cyc=%0d tgt=%0d got d=%h rdy=%b sn=%b st=%0d dn=%b ec=%0d exp d=%h rdy=%b sn=%b st=%0d dn=%b ec=%0d",
                    cyc, mon_e.cyc, mon_g.data, mon_g.ready, mon_g.sync_n, mon_g.state, mon_g.done, mon_g.errc,
                    mon_e.o.data, mon_e.o.ready, mon_e.o.sync_n, mon_e.o.state, mon_e.o.done, mon_e.o.errc);
    end
  end

  // Saturation run on the second instance: error bursts below its threshold
  initial begin
    int tot, run;
    rst2_n = 1'b0; en2 = 1'b0; d2 = 32'd0; k2 = 4'd0; de2 = 4'd0; nt2 = 4'd0; fin2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst2_n = 1'b1; en2 = 1'b1;
    repeat (4) begin d2 = COMMA; k2 = 4'hF; @(posedge clk); #1; end
    d2 = 32'h0000001C; k2 = 4'b0001; @(posedge clk); #1;
    repeat (4) begin d2 = 32'h7C000000; k2 = 4'b1000; @(posedge clk); #1; end
    chk("sat_enter_data", 64'(st2), 64'd3);
    k2 = 4'd0;
    tot = 0;
    while (tot < 65540) begin
      run = (65540 - tot < 254) ? (65540 - tot) : 254;
      repeat (run) begin d2 = $urandom; de2 = 4'b0100; @(posedge clk); #1; end
      tot += run;
      chk("sat_cnt", 64'(ecnt2), 64'((tot > 65535) ? 65535 : tot));
      chk("sat_state", 64'(st2), 64'd3);
      d2 = $urandom; de2 = 4'd0; @(posedge clk); #1;
    end
    chk("sat_ready", 64'(rdy2), 64'd1);
    fin2 = 1'b1;
  end

  initial begin
    int b;
    rst_n = 1'b0; en = 1'b0; din = 32'd0; kin = 4'd0; dein = 4'd0; ntin = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 64'({dout, rdy, syncn, st, done, ecnt}), 64'd0);
    rst_n = 1'b1;

    // CGS with an interrupting non-comma word
    commas(3); w(32'd0, 4'd0); commas(4);
    // ILAS: /R/, four /A/ multiframe ends, then the first data word
    commas(2); w(32'h0000001C, 4'b0001); w($urandom, 4'd0);
    w(32'h7C000000, 4'b1000); w(32'h7C000000, 4'b1000); w($urandom, 4'd0);
    w(32'h7C000000, 4'b1000); w(32'h7C000000, 4'b1000);
    w(32'hA5A5A5A5, 4'd0);
    repeat (5) w($urandom, 4'd0);
    // Error handling in DATA
    repeat (7) drive($urandom, 4'd0, 4'b0001, 4'd0, 1'b1);
    w($urandom, 4'd0);
    repeat (8) drive($urandom, 4'd0, 4'b0001, 4'd0, 1'b1);
    // /R/ in the wrong octet while waiting for ILAS
    commas(4); w(32'h1C000000, 4'b1000); commas(1);
    // ILAS timeout while sitting in ILAS_WAIT
    commas(4); commas(TO_N); commas(2);
    // Enable dropped for one cycle in the middle of ILAS
    commas(4); w(32'h0000001C, 4'b0001); w(32'h7C000000, 4'b1000); w($urandom, 4'd0);
    drive($urandom, 4'd0, 4'd0, 4'd0, 1'b0);
    commas(3); w(32'h0000001C, 4'b0001); w($urandom, 4'd0);
    // Randomised link bring-up episodes
    for (int ep = 0; ep < 40; ep++) episode();
    // Asynchronous reset in the middle of DATA
    go_to_data();
    repeat (3) err_word();
    w($urandom, 4'd0);
    chk("pre_rst_state", 64'(st), 64'd3);
    async_reset_check();
    go_to_data();
    err_word();
    repeat (4) w($urandom, 4'd0);

    #5;
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    b = 0;
    while (!fin2 && b < 90000) begin
      @(posedge clk);
      b++;
    end
    chk("sat_finished", 64'(fin2), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
